// File: rtl/regfile_read_port_pkg.sv
// Shared constants for the register-file read port.
//   DATA_W     : width of register data and snooped write data
//   ADDR_W     : register index width (32 registers)
//   RESP_DEPTH : entries in the response buffer
//   CNT_W      : width of the response buffer occupancy count (0..RESP_DEPTH)
package regfile_read_port_pkg;
    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int RESP_DEPTH = 2;
    localparam int CNT_W      = $clog2(RESP_DEPTH + 1);
endpackage

// File: rtl/resp_fifo2.sv
// Two-entry in-order response buffer with fall-through.
// When empty, the entry being pushed is already presented on head_o, so a
// push in cycle N+1 is visible to the consumer in that same cycle; if it is
// also popped in that cycle it is never stored.
// Ports:
//   clk_i, rst_ni : clock, synchronous active-low reset
//   push_i        : entry presented this cycle (push_data_i)
//   pop_i         : consumer takes head_o this cycle
//   head_o        : oldest entry, or push_data_i when empty
//   full_o        : both entries stored
//   empty_o       : nothing stored
//   count_o       : stored entries (0..2)
module resp_fifo2
    import regfile_read_port_pkg::*;
#(
    parameter int DW = regfile_read_port_pkg::DATA_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [DW-1:0]    push_data_i,
    input  logic             pop_i,
    output logic [DW-1:0]    head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    logic [DW-1:0]    mem_q [RESP_DEPTH];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             store;
    logic             unstore;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(RESP_DEPTH));
    assign count_o = count_q;
    assign head_o  = empty_o ? push_data_i : mem_q[rd_ptr_q];

    // A push that is popped straight through while empty is never stored.
    assign store   = push_i && !(empty_o && pop_i) && (!full_o || pop_i);
    assign unstore = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (store) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (unstore) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({store, unstore})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: it is only read while count_q says it is valid.
    always_ff @(posedge clk_i) begin
        if (store) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end
endmodule

// File: rtl/regfile_read_port.sv
// Register-file read port with write forwarding and a 2-entry response buffer.
// A request accepted in cycle N drives rf_raddr in N; the storage answers in
// N+1 and that value (or forwarded write data, or zero for register 0) is
// pushed into the response buffer in N+1.
// Ports:
//   clk, reset            : clock, synchronous active-low reset
//   req_valid/req_ready   : request handshake, req_addr = register index
//   rf_raddr / rf_rdata   : storage read address / data one cycle later
//   wr_en/wr_addr/wr_data : snooped register write port
//   resp_valid/resp_ready : response handshake, resp_data = read result
// Handshakes: a transfer happens in a cycle where valid and ready are both
// high; valid does not depend on ready.
module regfile_read_port #(
    parameter int DATA_W = regfile_read_port_pkg::DATA_W,
    parameter int ADDR_W = regfile_read_port_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data
);
    import regfile_read_port_pkg::*;

    logic              inflight_q, inflight_d;
    logic              zero_q, zero_d;
    logic              fwd_q, fwd_d;
    logic [DATA_W-1:0] fwd_data_q, fwd_data_d;

    logic              accept;
    logic [DATA_W-1:0] cap_data;
    logic              pop;
    logic [DATA_W-1:0] fifo_head;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign rf_raddr = req_addr;

    // occupancy + in-flight < 2; a pop this cycle does not free a slot.
    assign req_ready = reset && !fifo_full && !((fifo_count == CNT_W'(1)) && inflight_q);
    assign accept    = req_valid && req_ready;

    // Forwarding is decided in the acceptance cycle: the storage read issued
    // then cannot yet see a write landing at the end of that same cycle.
    assign zero_d     = (req_addr == '0);
    assign fwd_d      = wr_en && (wr_addr == req_addr) && (req_addr != '0);
    assign fwd_data_d = wr_data;
    assign inflight_d = accept;

    assign cap_data = zero_q ? '0 : (fwd_q ? fwd_data_q : rf_rdata);

    // Outputs are held quiet while reset is low so nothing accepted before
    // reset can surface.
    assign resp_valid = reset && (!fifo_empty || inflight_q);
    assign resp_data  = resp_valid ? fifo_head : '0;
    assign pop        = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            inflight_q <= 1'b0;
            zero_q     <= 1'b0;
            fwd_q      <= 1'b0;
            fwd_data_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            if (accept) begin
                zero_q     <= zero_d;
                fwd_q      <= fwd_d;
                fwd_data_q <= fwd_data_d;
            end
        end
    end

    resp_fifo2 #(
        .DW(DATA_W)
    ) u_resp_fifo (
        .clk_i       (clk),
        .rst_ni      (reset),
        .push_i      (inflight_q),
        .push_data_i (cap_data),
        .pop_i       (pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );
endmodule

// File: tb/tb_regfile_read_port.sv
module tb_regfile_read_port;
  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_addr;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] mem [32];

  // clock / reset block
  always #5 clk = ~clk;

  regfile_read_port dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .rf_raddr   (rf_raddr),
    .rf_rdata   (rf_rdata),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  // register storage: read data one cycle after the address, writes at edge
  always @(posedge clk) begin
    rf_rdata <= mem[rf_raddr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // let combinational outputs settle after driving inputs
  task automatic settle();
    #1;
  endtask

  // hand-written storage contents after the directed writes below
  function automatic logic [31:0] exp_mem(input int a);
    case (a)
      1:       return 32'h0000_0BAD;
      5:       return 32'h0000_0055;
      7:       return 32'h0000_1234;
      default: return 32'h0000_0100 + 32'(a);
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'h100 + i;
    mem[0] = 32'hFFFF_FFFF;
    mem[5] = 32'h0000_0001;
    mem[7] = 32'h0000_1234;
    reset = 1'b0; req_valid = 1'b0; req_addr = 5'd3;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; resp_ready = 1'b1;
    tick(); tick();
    reset = 1'b1;
    settle();
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("raddr_follows", {27'd0, rf_raddr}, 32'd3);
    tick();

    // basic read of register 7
    req_valid = 1'b1; req_addr = 5'd7;
    settle();
    check("r7_ready", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    settle();
    check("r7_valid", {31'd0, resp_valid}, 32'd1);
    check("r7_data", resp_data, 32'h0000_1234);
    tick();
    settle();
    check("r7_drained", {31'd0, resp_valid}, 32'd0);

    // register 0 always reads zero, even with a write to 0
    req_valid = 1'b1; req_addr = 5'd0;
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h0000_CAFE;
    tick();
    req_valid = 1'b0; wr_en = 1'b0;
    settle();
    check("r0_valid", {31'd0, resp_valid}, 32'd1);
    check("r0_data", resp_data, 32'd0);
    tick();

    // forwarding in the acceptance cycle; a capture-cycle write is ignored
    req_valid = 1'b1; req_addr = 5'd5;
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    tick();
    req_valid = 1'b0; wr_addr = 5'd5; wr_data = 32'h0000_0055;
    settle();
    check("fwd_data", resp_data, 32'hDEAD_BEEF);
    tick();
    wr_en = 1'b0;

    // back-pressure: two reads fill the port, third waits
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 5'd1;
    settle();
    check("bp_ready1", {31'd0, req_ready}, 32'd1);
    tick();
    req_addr = 5'd2;
    settle();
    check("bp_ready2", {31'd0, req_ready}, 32'd1);
    check("bp_head1a", resp_data, 32'h0000_0101);
    tick();
    req_addr = 5'd3;
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 32'h0000_0BAD;
    settle();
    check("bp_ready3", {31'd0, req_ready}, 32'd0);
    check("bp_head1b", resp_data, 32'h0000_0101);
    tick();
    wr_en = 1'b0;
    settle();
    check("bp_full_ready", {31'd0, req_ready}, 32'd0);
    check("bp_snapshot", resp_data, 32'h0000_0101);
    tick();
    resp_ready = 1'b1;
    settle();
    check("bp_pop1", resp_data, 32'h0000_0101);
    check("bp_pop_no_free", {31'd0, req_ready}, 32'd0);
    tick();
    settle();
    check("bp_pop2", resp_data, 32'h0000_0102);
    check("bp_accept3", {31'd0, req_ready}, 32'd1);
    tick();
    req_valid = 1'b0;
    settle();
    check("bp_valid3", {31'd0, resp_valid}, 32'd1);
    check("bp_pop3", resp_data, 32'h0000_0103);
    tick();
    settle();
    check("bp_empty", {31'd0, resp_valid}, 32'd0);

    // reset right after an accepted read drops it
    req_valid = 1'b1; req_addr = 5'd9;
    tick();
    req_valid = 1'b0; reset = 1'b0;
    settle();
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    tick();
    reset = 1'b1;
    settle();
    check("post_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);
    tick();
    settle();
    check("post_rst_quiet", {31'd0, resp_valid}, 32'd0);

    // 20 back-to-back reads of registers 1..20
    resp_ready = 1'b1;
    for (int k = 0; k <= 20; k++) begin
      req_valid = (k < 20);
      req_addr = 5'(k + 1);
      settle();
      if (k < 20) check($sformatf("stream_ready%0d", k), {31'd0, req_ready}, 32'd1);
      if (k >= 1) begin
        check($sformatf("stream_valid%0d", k), {31'd0, resp_valid}, 32'd1);
        check($sformatf("stream_data%0d", k), resp_data, exp_mem(k));
      end
      tick();
    end
    req_valid = 1'b0;
    settle();
    check("stream_done", {31'd0, resp_valid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/regfile_read_port.md
REGFILE_READ_PORT -- requirements
Module: regfile_read_port

Interface
REQ-001 Parameter DATA_W, default 32, width of read data and snooped write data.
REQ-002 Parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 req_valid  input  1  read request present.
REQ-006 req_ready  output  1  block can accept a request this cycle.
REQ-007 req_addr  input  ADDR_W  register index to read.
REQ-008 rf_raddr  output  ADDR_W  address to the register storage; storage returns data one cycle later.
REQ-009 rf_rdata  input  DATA_W  storage read data for the address driven in the previous cycle.
REQ-010 wr_en  input  1  snooped write enable of the register write port.
REQ-011 wr_addr  input  ADDR_W  snooped write address.
REQ-012 wr_data  input  DATA_W  snooped write data.
REQ-013 resp_valid  output  1  response data available.
REQ-014 resp_ready  input  1  consumer takes the response this cycle.
REQ-015 resp_data  output  DATA_W  read result.

Function
REQ-016 A request SHALL be accepted only in a cycle where req_valid and req_ready are both high.
REQ-017 rf_raddr SHALL equal req_addr combinationally in every cycle.
REQ-018 Pipeline: acceptance in cycle N SHALL set an in-flight flag, and rf_rdata SHALL be captured in cycle N+1 into the response buffer.
REQ-019 The response buffer SHALL be a 2-entry in-order FIFO, and responses SHALL leave in request order.
REQ-020 req_ready SHALL be high iff (buffer occupancy + in-flight flag) < 2, with a pop in the same cycle not counted.
REQ-021 Earliest latency: a request accepted in cycle N SHALL produce resp_valid high in cycle N+1 when the buffer is empty.
REQ-022 resp_valid SHALL equal buffer-not-empty, and resp_data SHALL be the head entry.
REQ-023 A pop SHALL occur when resp_valid and resp_ready are both high, and a simultaneous push and pop SHALL keep occupancy unchanged.
REQ-024 Address 0 SHALL always return 0, regardless of rf_rdata or snooped writes.
REQ-025 Forwarding: if wr_en is high in the acceptance cycle with wr_addr == req_addr != 0, the captured value SHALL be that cycle's wr_data instead of rf_rdata.
REQ-026 A write in the capture cycle (N+1) SHALL NOT alter the captured value, because storage already reflects writes before cycle N+1.
REQ-027 Entries already in the buffer SHALL be snapshots and SHALL NOT be updated by later writes.
REQ-028 When the buffer is full and resp_ready is low, req_ready SHALL be low and no data SHALL be lost or overwritten.
REQ-029 FIFO pointers SHALL wrap modulo 2, and occupancy SHALL never exceed 2 or underflow below 0.

Reset
REQ-030 While reset is low at a rising edge, the block SHALL clear occupancy, pointers and the in-flight flag, and SHALL discard any in-flight read.
REQ-031 After reset: resp_valid=0, resp_data=0 and req_ready=1 in the first cycle with reset high.
REQ-032 Reset asserted mid-operation SHALL drop all pending responses, and no response SHALL appear for requests accepted before reset.

Structure
REQ-033 Shared package SHALL hold the constants DATA_W=32 and ADDR_W=5 and the FIFO depth constant RESP_DEPTH=2.
REQ-034 The response buffer SHALL be a sub-module named resp_fifo2 (push/pop/full/empty/count).
REQ-035 Forward-match compare and in-flight tracking SHALL live in the top module.

Verification
REQ-036 Storage reg 7=0x0000_1234, read addr 7 at cycle 1 with resp_ready=1 -> resp_valid at cycle 2, resp_data=0x0000_1234.
REQ-037 Read addr 0 while storage returns 0xFFFF_FFFF and wr_en=1, wr_addr=0 -> resp_data=0.
REQ-038 Read addr 5 with wr_en=1, wr_addr=5, wr_data=0xDEAD_BEEF in the same cycle, storage old value 0x1 -> resp_data=0xDEAD_BEEF.
REQ-039 resp_ready=0, issue reads of 1, 2, 3 back-to-back -> two accepted, req_ready low on the third; release resp_ready -> responses for 1 then 2, then the third is accepted.
REQ-040 Accept a read of addr 9, assert reset low next cycle -> resp_valid stays 0, req_ready=1 after reset releases.
REQ-041 Continuous reads with resp_ready=1 for 20 cycles -> one response per cycle, in order, no stalls after the first.
